// File: rtl/testbasic6_sender_if.sv
// Handshake bundle for the two-port sender: a data word, valid (notify) and ready (sync) per port.
// The bundle also carries the combined transfer count.
interface testbasic6_sender_if;
  logic [31:0] b_out;
  logic        b_out_sync;
  logic        b_out_notify;
  logic [31:0] b_out2;
  logic        b_out2_sync;
  logic        b_out2_notify;
  logic [7:0]  sent_cnt;

  // Handshake: a port's word transfers on a rising edge where notify=1 and sync=1.
  // While notify=1 the word holds stable, and sync is ignored while notify=0.
  modport master (
    output b_out, b_out_notify, b_out2, b_out2_notify, sent_cnt,
    input  b_out_sync, b_out2_sync
  );

  modport slave (
    input  b_out, b_out_notify, b_out2, b_out2_notify, sent_cnt,
    output b_out_sync, b_out2_sync
  );
endinterface

// File: rtl/testbasic6_sender.sv
// Sends pairs of words: var on port A, then var+1 on port B, and then advances var by 2.
// All outputs are registered, and state is exposed on state_dbg.
module testbasic6_sender #(
  parameter logic [31:0] RESET_VAR = 32'd4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  testbasic6_sender_if.master        bus,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] var_q, var_d;
  logic [31:0] b_out_q, b_out_d;
  logic [31:0] b_out2_q, b_out2_d;
  logic        a_notify_q, a_notify_d;
  logic        b_notify_q, b_notify_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      var_q      <= RESET_VAR;
      b_out_q    <= 32'd0;
      b_out2_q   <= 32'd0;
      a_notify_q <= 1'b0;
      b_notify_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      var_q      <= var_d;
      b_out_q    <= b_out_d;
      b_out2_q   <= b_out2_d;
      a_notify_q <= a_notify_d;
      b_notify_q <= b_notify_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    var_d      = var_q;
    b_out_d    = b_out_q;
    b_out2_d   = b_out2_q;
    a_notify_d = a_notify_q;
    b_notify_d = b_notify_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        a_notify_d = 1'b0;
        b_notify_d = 1'b0;
        if (en) begin
          state_d    = SEND_A;
          b_out_d    = var_q;
          a_notify_d = 1'b1;
        end
      end
      SEND_A: begin
        if (a_notify_q && bus.b_out_sync) begin
          state_d    = SEND_B;
          a_notify_d = 1'b0;
          b_out2_d   = var_q + 32'd1;
          b_notify_d = 1'b1;
          cnt_d      = cnt_q + 8'd1;
        end
      end
      SEND_B: begin
        // en is only consulted once B completes, so a started pair is never cut short.
        if (b_notify_q && bus.b_out2_sync) begin
          b_notify_d = 1'b0;
          var_d      = var_q + 32'd2;
          cnt_d      = cnt_q + 8'd1;
          if (en) begin
            state_d    = SEND_A;
            b_out_d    = var_q + 32'd2;
            a_notify_d = 1'b1;
          end else begin
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        a_notify_d = 1'b0;
        b_notify_d = 1'b0;
      end
    endcase
  end

  assign bus.b_out         = b_out_q;
  assign bus.b_out2        = b_out2_q;
  assign bus.b_out_notify  = a_notify_q;
  assign bus.b_out2_notify = b_notify_q;
  assign bus.sent_cnt      = cnt_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_testbasic6_sender.sv
// Directed test of testbasic6_sender with hand-computed expectations.
// A second instance starts near the signed wrap point.
module tb_testbasic6_sender;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       en_w = 1'b0;
  logic [1:0] state_dbg, state_dbg_w;
  int         n_vec = 0;
  int         n_err = 0;

  testbasic6_sender_if bus();
  testbasic6_sender_if w_bus();

  always #5 clk = ~clk;

  testbasic6_sender u_dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus.master), .state_dbg(state_dbg)
  );

  testbasic6_sender #(.RESET_VAR(32'h7FFF_FFFF)) u_wrap (
    .clk(clk), .rst(rst), .en(en_w), .bus(w_bus.master), .state_dbg(state_dbg_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string t, input logic [31:0] eb, input logic ea,
                         input logic [31:0] eb2, input logic enb, input logic [7:0] ec);
    check({t, ".b_out"},    bus.b_out, eb);
    check({t, ".notify_a"}, {31'd0, bus.b_out_notify}, {31'd0, ea});
    check({t, ".b_out2"},   bus.b_out2, eb2);
    check({t, ".notify_b"}, {31'd0, bus.b_out2_notify}, {31'd0, enb});
    check({t, ".cnt"},      {24'd0, bus.sent_cnt}, {24'd0, ec});
  endtask

  // The two valids must never be high together.
  always @(negedge clk) begin
    if (rst) check("mutex", {31'd0, bus.b_out_notify & bus.b_out2_notify}, 32'd0);
  end

  initial begin
    bus.b_out_sync    = 1'b0;
    bus.b_out2_sync   = 1'b0;
    w_bus.b_out_sync  = 1'b0;
    w_bus.b_out2_sync = 1'b0;

    // Reset state
    tick();
    tick();
    chk_out("rst", 32'd0, 1'b0, 32'd0, 1'b0, 8'd0);
    check("rst.state", {30'd0, state_dbg}, 32'd0);

    // Both syncs tied high: back-to-back pairs, one transfer per cycle
    rst = 1'b1; en = 1'b1; bus.b_out_sync = 1'b1; bus.b_out2_sync = 1'b1;
    tick(); chk_out("bb1", 32'd4, 1'b1, 32'd0, 1'b0, 8'd0);
    check("bb1.state", {30'd0, state_dbg}, 32'd1);
    tick(); chk_out("bb2", 32'd4, 1'b0, 32'd5, 1'b1, 8'd1);
    check("bb2.state", {30'd0, state_dbg}, 32'd2);
    tick(); chk_out("bb3", 32'd6, 1'b1, 32'd5, 1'b0, 8'd2);
    tick(); chk_out("bb4", 32'd6, 1'b0, 32'd7, 1'b1, 8'd3);
    en = 1'b0;
    tick(); chk_out("bb5", 32'd6, 1'b0, 32'd7, 1'b0, 8'd4);
    check("bb5.state", {30'd0, state_dbg}, 32'd0);
    tick(); chk_out("bb6", 32'd6, 1'b0, 32'd7, 1'b0, 8'd4);

    rst = 1'b0; tick(); rst = 1'b1;

    // A held off for 5 cycles while B's sync is high; then en drops mid-pair
    en = 1'b1; bus.b_out_sync = 1'b0; bus.b_out2_sync = 1'b1;
    tick(); chk_out("hold0", 32'd4, 1'b1, 32'd0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick(); chk_out($sformatf("hold%0d", i + 1), 32'd4, 1'b1, 32'd0, 1'b0, 8'd0);
    end
    bus.b_out_sync = 1'b1; en = 1'b0;
    tick(); chk_out("drop1", 32'd4, 1'b0, 32'd5, 1'b1, 8'd1);
    tick(); chk_out("drop2", 32'd4, 1'b0, 32'd5, 1'b0, 8'd2);
    check("drop2.state", {30'd0, state_dbg}, 32'd0);
    tick(); chk_out("drop3", 32'd4, 1'b0, 32'd5, 1'b0, 8'd2);

    // var advanced to 6; B held off while A's sync stays high
    en = 1'b1; bus.b_out2_sync = 1'b0;
    tick(); chk_out("var6", 32'd6, 1'b1, 32'd5, 1'b0, 8'd2);
    tick(); chk_out("bhold1", 32'd6, 1'b0, 32'd7, 1'b1, 8'd3);
    tick(); chk_out("bhold2", 32'd6, 1'b0, 32'd7, 1'b1, 8'd3);
    tick(); chk_out("bhold3", 32'd6, 1'b0, 32'd7, 1'b1, 8'd3);
    check("bhold3.state", {30'd0, state_dbg}, 32'd2);

    // Asynchronous reset while in SEND_B
    rst = 1'b0;
    #1;
    chk_out("arst", 32'd0, 1'b0, 32'd0, 1'b0, 8'd0);
    check("arst.state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; bus.b_out_sync = 1'b1; bus.b_out2_sync = 1'b1;
    tick(); chk_out("rel", 32'd4, 1'b1, 32'd0, 1'b0, 8'd0);

    // sent_cnt wraps after 256 transfers
    repeat (255) tick();
    chk_out("cnt255", 32'd258, 1'b0, 32'd259, 1'b1, 8'd255);
    tick(); chk_out("cnt0", 32'd260, 1'b1, 32'd259, 1'b0, 8'd0);

    // 32-bit wrap from a start value of 0x7FFFFFFF
    en_w = 1'b1; w_bus.b_out_sync = 1'b1; w_bus.b_out2_sync = 1'b1;
    tick(); check("wrap.a0", w_bus.b_out, 32'h7FFF_FFFF);
    tick(); check("wrap.b0", w_bus.b_out2, 32'h8000_0000);
    check("wrap.nb0", {31'd0, w_bus.b_out2_notify}, 32'd1);
    tick(); check("wrap.a1", w_bus.b_out, 32'h8000_0001);
    tick(); check("wrap.b1", w_bus.b_out2, 32'h8000_0002);
    check("wrap.cnt", {24'd0, w_bus.sent_cnt}, 32'd3);
    en_w = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/testbasic6_sender.md
TESTBASIC6_SENDER -- requirements
Module: testbasic6_sender

Interface
- REQ-001: clk  input  1  sole clock; all state updates on rising edge.
- REQ-002: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- REQ-003: en  input  1  permission to start a new A/B transfer pair; sampled only in IDLE and at B completion.
- REQ-004: b_out  output  32 (integer)  data word for port A.
- REQ-005: b_out_sync  input  1  port A receiver ready/accept.
- REQ-006: b_out_notify  output  1  port A data valid.
- REQ-007: b_out2  output  32 (integer)  data word for port B.
- REQ-008: b_out2_sync  input  1  port B receiver ready/accept.
- REQ-009: b_out2_notify  output  1  port B data valid.
- REQ-010: sent_cnt  output  8  count of completed transfers, both ports combined.

Function
- REQ-011: Transfer on a port SHALL complete at a rising edge where that port's notify=1 and sync=1.
- REQ-012: FSM states SHALL be IDLE, SEND_A, SEND_B; all outputs registered.
- REQ-013: Internal register var SHALL be 32-bit, reset value 4.
- REQ-014: IDLE: if en=1, go to SEND_A, b_out<=var, b_out_notify<=1; else remain, notifies 0.
- REQ-015: SEND_A: b_out and b_out_notify=1 SHALL hold stable until A completes.
- REQ-016: On A completion: b_out_notify<=0, b_out2<=var+1, b_out2_notify<=1, sent_cnt<=sent_cnt+1, go to SEND_B.
- REQ-017: SEND_B: b_out2 and b_out2_notify=1 SHALL hold stable until B completes.
- REQ-018: On B completion: b_out2_notify<=0, var<=var+2, sent_cnt+1; if en=1 go to SEND_A with b_out<=var+2 and b_out_notify<=1 (back-to-back, no idle cycle); else IDLE.
- REQ-019: b_out_notify and b_out2_notify SHALL never both be 1.
- REQ-020: sync inputs SHALL be ignored when the matching notify is 0 (no state change, no count).
- REQ-021: en deassertion during SEND_A/SEND_B SHALL NOT abort the pair; B is always sent after A.
- REQ-022: Arithmetic SHALL be 32-bit two's-complement wrap (0x7FFFFFFF+1 = 0x80000000; 0xFFFFFFFF+1 = 0).
- REQ-023: sent_cnt SHALL wrap 255->0.
- REQ-024: sync held high continuously SHALL yield one transfer per cycle of notify=1; the minimum pair time is 2 cycles.

Reset
- REQ-025: While rst=0: state IDLE, var=4, b_out=0, b_out2=0, b_out_notify=0, b_out2_notify=0, sent_cnt=0.
- REQ-026: Reset assertion mid-transfer SHALL immediately drop both notifies; the pending transfer is lost.
- REQ-027: First rising edge after rst release SHALL evaluate IDLE rules normally.

Verification
- REQ-028: Reset release, en=1, both syncs tied 1 -> b_out=4 (notify A), then b_out2=5 (notify B), then b_out=6, b_out2=7; sent_cnt increments every cycle.
- REQ-029: en=1, b_out_sync=0 for 5 cycles then 1 -> b_out=4 and notify A held stable for all 6 cycles; b_out2 notify rises on the following edge.
- REQ-030: en dropped to 0 during SEND_A -> pair completes (4 then 5); FSM returns to IDLE; notifies stay 0; var=6.
- REQ-031: b_out2_sync=1 while in SEND_A -> no B transfer, sent_cnt unchanged until A completes.
- REQ-032: var forced near wrap via repeated pairs (or a bench-preloaded start) to 0x7FFFFFFF -> b_out2=0x80000000; 256 transfers -> sent_cnt=0.
- REQ-033: rst=0 asserted in SEND_B -> notifies 0 asynchronously; after release with en=1, b_out=4 again.
